// File: rtl/ahb_pkg.sv
// -----------------------------------------------------------------------------
// ahb_pkg -- shared AHB definitions
//   Transfer-type (htrans) and response (hresp) encodings, and the state enum
//   of the bus arbiter. Imported by ahb_arbiter_if, ahb_rr_picker and
//   ahb_arbiter.
// -----------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    ARB_PARK = 2'b00,
    ARB_OWN  = 2'b01,
    ARB_LOCK = 2'b10
  } arb_state_e;

  // Width of a master index (hmaster); covers up to four masters.
  localparam int MST_IDX_W = 2;

  // Beat-counter width; QUANTUM must fit.
  localparam int BEAT_CNT_W = 8;

endpackage : ahb_pkg

// File: rtl/ahb_arbiter_if.sv
// -----------------------------------------------------------------------------
// ahb_arbiter_if -- arbitration signals between the bus masters and the arbiter
//   hbusreq[NUM_MST]  per-master bus request          (master -> arbiter)
//   hlock[NUM_MST]    per-master locked request       (master -> arbiter)
//   htrans[2]         muxed transfer type of owner    (master -> arbiter)
//   hready            muxed transfer done             (slave side -> arbiter)
//   hgrant[NUM_MST]   one-hot grant                   (arbiter -> masters)
//   hmaster[2]        address-phase owner index       (arbiter -> bus)
//   hmastlock         owner's transfer is locked      (arbiter -> bus)
// Modports: master (request side), slave (the arbiter itself).
// -----------------------------------------------------------------------------
interface ahb_arbiter_if #(
  parameter int NUM_MST = 3
);
  import ahb_pkg::*;

  logic [NUM_MST-1:0]   hbusreq;
  logic [NUM_MST-1:0]   hlock;
  htrans_e              htrans;
  logic                 hready;
  logic [NUM_MST-1:0]   hgrant;
  logic [MST_IDX_W-1:0] hmaster;
  logic                 hmastlock;

  modport master (
    output hbusreq, hlock, htrans, hready,
    input  hgrant, hmaster, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, htrans, hready,
    output hgrant, hmaster, hmastlock
  );

endinterface : ahb_arbiter_if

// File: rtl/ahb_rr_picker.sv
// -----------------------------------------------------------------------------
// ahb_rr_picker -- combinational winner search over the request vector
//   req_i[NUM_MST]  requests (indices >= NUM_MST do not exist, so are absent)
//   last_i[2]       index of the current grant
//   winner_o[2]     selected master index
//   valid_o         at least one request present
// Default: rotating priority, searching from (last_i + 1) mod NUM_MST upward
// with wrap-around, so last_i itself has the lowest priority.
// Macro AHB_ARB_FIXED_PRIO_EN: lowest-index requester wins, last_i ignored.
// -----------------------------------------------------------------------------
module ahb_rr_picker
  import ahb_pkg::*;
#(
  parameter int NUM_MST = 3
) (
  input  logic [NUM_MST-1:0]   req_i,
  input  logic [MST_IDX_W-1:0] last_i,
  output logic [MST_IDX_W-1:0] winner_o,
  output logic                 valid_o
);

  logic [MST_IDX_W-1:0] idx;

`ifdef AHB_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_i;

  // Scan high to low so the lowest-index requester is written last and wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      idx = MST_IDX_W'(i);
      if (req_i[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end
    end
  end
`else
  // Scan offsets from farthest (last_i itself) to nearest (last_i + 1), so
  // the nearest requester after the current owner is written last and wins.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int i = NUM_MST; i >= 1; i--) begin
      idx = MST_IDX_W'((int'(last_i) + i) % NUM_MST);
      if (req_i[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end
    end
  end
`endif

endmodule : ahb_rr_picker

// File: rtl/ahb_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_arbiter -- AHB bus arbiter with parking, round-robin and locked transfers
//   hclk    bus clock, all state changes on the rising edge
//   hreset  asynchronous, active-high reset
//   bus     ahb_arbiter_if.slave (hbusreq, hlock, htrans, hready in;
//           hgrant, hmaster, hmastlock out, all registered)
// Parameters: NUM_MST (2..4), QUANTUM (2..255 owner beats before forced
// re-arbitration), DEF_MST (parked master).
// Macro AHB_ARB_FIXED_PRIO_EN: fixed lowest-index priority, QUANTUM ignored.
//
// States: PARK grants DEF_MST while nobody requests; OWN holds a master until
// it releases the bus or uses up its quantum at a transfer boundary; LOCK
// holds the owner unconditionally while it keeps hlock asserted. Nothing
// moves on a cycle with hready=0.
// -----------------------------------------------------------------------------
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MST = 3,
  parameter int QUANTUM = 16,
  parameter int DEF_MST = 0
) (
  input logic        hclk,
  input logic        hreset,
  ahb_arbiter_if.slave bus
);

  localparam logic [BEAT_CNT_W-1:0] QUANTUM_C = BEAT_CNT_W'(QUANTUM);
  localparam logic [MST_IDX_W-1:0]  DEF_IDX   = MST_IDX_W'(DEF_MST);
  localparam logic [NUM_MST-1:0]    ONE_HOT0  = {{(NUM_MST-1){1'b0}}, 1'b1};

  arb_state_e            state_q;
  logic [MST_IDX_W-1:0]  grant_idx_q;
  logic [NUM_MST-1:0]    hgrant_q;
  logic [MST_IDX_W-1:0]  hmaster_q;
  logic                  hmastlock_q;
  logic [BEAT_CNT_W-1:0] cnt_q;
  logic [BEAT_CNT_W-1:0] cnt_d;

  logic                  owner_req;
  logic                  owner_lock;
  logic                  boundary;
  logic                  quantum_hit;
  logic                  rearb;
  logic [MST_IDX_W-1:0]  pick_idx;
  logic                  pick_valid;
  logic [MST_IDX_W-1:0]  rearb_idx;
  arb_state_e            rearb_state;

  ahb_rr_picker #(
    .NUM_MST (NUM_MST)
  ) u_picker (
    .req_i    (bus.hbusreq),
    .last_i   (grant_idx_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    owner_req  = bus.hbusreq[grant_idx_q];
    owner_lock = bus.hlock[grant_idx_q];
    // A grant may only move where a new transfer starts (or none is running);
    // SEQ and BUSY are mid-burst.
    boundary   = (bus.htrans == HTRANS_IDLE) || (bus.htrans == HTRANS_NONSEQ);
`ifdef AHB_ARB_FIXED_PRIO_EN
    quantum_hit = 1'b0;
`else
    quantum_hit = (cnt_q == QUANTUM_C);
`endif
    rearb = boundary && (!owner_req || quantum_hit);

    // Count real beats only, saturating at QUANTUM.
    cnt_d = cnt_q;
    if (((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ)) &&
        (cnt_q != QUANTUM_C)) begin
      cnt_d = cnt_q + BEAT_CNT_W'(1);
    end

    // Outcome of a re-arbitration: nobody left -> park on DEF_MST.
    rearb_idx   = pick_valid ? pick_idx : DEF_IDX;
    rearb_state = pick_valid ? ARB_OWN : ARB_PARK;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= ARB_PARK;
      grant_idx_q <= DEF_IDX;
      hgrant_q    <= ONE_HOT0 << DEF_IDX;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
      cnt_q       <= '0;
    end else if (bus.hready) begin
      // NOTE: registered state uses non-blocking assignments so every branch
      // sees the pre-edge values of grant_idx_q/cnt_q.
      // hmaster/hmastlock trail the grant by one hready cycle.
      hmaster_q   <= grant_idx_q;
      hmastlock_q <= bus.hlock[grant_idx_q];

      unique case (state_q)
        ARB_PARK: begin
          cnt_q <= '0;
          if (pick_valid) begin
            state_q     <= ARB_OWN;
            grant_idx_q <= pick_idx;
            hgrant_q    <= ONE_HOT0 << pick_idx;
          end
        end

        ARB_OWN: begin
          if (owner_req && owner_lock) begin
            state_q <= ARB_LOCK;
            cnt_q   <= cnt_d;
          end else if (rearb) begin
            state_q     <= rearb_state;
            grant_idx_q <= rearb_idx;
            hgrant_q    <= ONE_HOT0 << rearb_idx;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ARB_LOCK: begin
          // Releasing the lock applies the OWN rules on that same cycle.
          if (!owner_lock && rearb) begin
            state_q     <= rearb_state;
            grant_idx_q <= rearb_idx;
            hgrant_q    <= ONE_HOT0 << rearb_idx;
            cnt_q       <= '0;
          end else begin
            if (!owner_lock) begin
              state_q <= ARB_OWN;
            end
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q     <= ARB_PARK;
          grant_idx_q <= DEF_IDX;
          hgrant_q    <= ONE_HOT0 << DEF_IDX;
          cnt_q       <= '0;
        end
      endcase
    end
  end

  assign bus.hgrant    = hgrant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = hmastlock_q;

endmodule : ahb_arbiter
